word_seq_1553: RTL and testbench
================================

Name: word_seq_1553

Overview:
- Parametrised MIL-STD-1553 word sequencer. It replays a programmable list of 18-bit entries ({csw, dw, dword[15:0]}) into an encoder_1553-style transmit interface.
- Per-word handshake on tx_busy, with a programmable inter-word gap, loop mode, stop request and busy-timeout detection.
- It is a synthesizable successor to the ad-hoc ROM/gap pacing logic used to drive the BC encoder. It sits between a host loader (or preload logic) and the encoder.

Parameters:
- DEPTH, 512, number of sequence entries; must be a power of two, ≥ 2.
- AW, 9, address width; equals log2(DEPTH).
- GW, 8, width of the gap_cycles input.
- TO_CYCLES, 16, cycles allowed for tx_busy to rise after a word is issued.

Ports:
- clk  in  1  encoder-domain clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  host write strobe into the entry memory.
- wr_addr  in  AW  host write address.
- wr_data  in  18  entry: [17] csw, [16] dw, [15:0] dword.
- start  in  1  one-cycle pulse; begins playback at address 0.
- stop  in  1  one-cycle pulse; ends playback after the current word.
- loop_en  in  1  when 1, wraps to address 0 after last_addr.
- last_addr  in  AW  address of the final entry in the sequence.
- gap_cycles  in  GW  idle cycles inserted after tx_busy falls.
- tx_busy  in  1  encoder busy.
- tx_dword  out  16  word to the encoder; valid while tx_csw or tx_dw is 1.
- tx_csw  out  1  one-cycle command/status sync strobe.
- tx_dw  out  1  one-cycle data sync strobe.
- running  out  1  sequencer is active (not IDLE).
- done  out  1  one-cycle pulse when playback ends normally.
- err_timeout  out  1  sticky; tx_busy failed to rise within TO_CYCLES.
- rd_addr  out  AW  current entry address.
- word_cnt  out  16  words issued since start; saturates at 16'hFFFF.

Behaviour:
- Reset: all outputs 0; state IDLE; stop_pend = 0. Memory contents are not reset.
- Memory: DEPTH×18 with a synchronous write port. The read is registered, giving 1-cycle read latency.
  - A host write to the address being read in the same cycle returns the old data.
- States: IDLE, FETCH, ISSUE, WAIT_HI, WAIT_LO, GAP.
- IDLE:
  - start → rd_addr = 0, word_cnt = 0, err_timeout cleared, goto FETCH.
  - start is ignored outside IDLE.
- FETCH: one cycle for the memory read, then goto ISSUE.
- ISSUE (one cycle):
  - Drive tx_dword = entry[15:0], tx_csw = entry[17], tx_dw = entry[16].
  - If csw and dw are both 1, csw wins and dw is forced to 0.
  - Increment word_cnt; reset the timeout counter; goto WAIT_HI.
  - An entry with csw = dw = 0 is an end marker: no strobe, no count; end playback as at last_addr with loop_en = 0.
- WAIT_HI:
  - tx_busy = 1 → goto WAIT_LO.
  - Timeout counter reaches TO_CYCLES → set err_timeout; goto IDLE with no done pulse.
- WAIT_LO:
  - tx_busy = 0 → load the gap counter with gap_cycles; goto GAP.
  - If gap_cycles = 0, skip GAP and evaluate the next step immediately.
- GAP: count down to 0, then take the next step.
- Next-step priority:
  1. stop_pend → IDLE with done.
  2. rd_addr == last_addr and loop_en = 0 → IDLE with done.
  3. rd_addr == last_addr and loop_en = 1 → rd_addr = 0, FETCH.
  4. Otherwise rd_addr + 1 (wraps modulo DEPTH), FETCH.
- stop:
  - Latched into stop_pend in any non-IDLE state and cleared on entry to IDLE.
  - The word in flight always completes.
- Latency: start → first strobe is 2 cycles (FETCH, ISSUE).
- Word-to-word period is T_busy + gap_cycles + 3 cycles (1 for WAIT_LO exit, plus FETCH, ISSUE).
- Sampling:
  - gap_cycles is sampled at WAIT_LO exit.
  - last_addr and loop_en are sampled at each next-step decision.
  - Changing them mid-run takes effect at the next boundary.
- Reset mid-operation: immediate return to IDLE. Strobes deassert asynchronously and no done pulse is produced.
- running = 1 in every state except IDLE.
- done and the strobes are single-cycle and registered.

Test Plan:
- Load 0:{1,0,5555} 1:{0,1,ABCD} 2:{0,1,1234}; last_addr = 2, gap = 4. Encoder model busy for 40 cycles. Start → three strobes (csw, dw, dw) with matching dwords; strobe spacing 47 cycles; done pulse; word_cnt = 3; running = 0.
- Same load with loop_en = 1; pulse stop during the 5th word → words 0,1,2,0,1 issued, then done; word_cnt = 5; no 6th strobe.
- Entry 1 = {0,0,xxxx} with last_addr = 5 → only word 0 issued; done after its gap; word_cnt = 1.
- Encoder model never asserts busy → err_timeout = 1 exactly TO_CYCLES = 16 cycles after the strobe; IDLE; no done; the next start clears err_timeout.
- gap = 0 with last_addr = DEPTH-1 and loop_en = 1 → rd_addr wraps 511 → 0; entry 0 re-issued; spacing T_busy + 3.
- Assert reset during WAIT_LO → all outputs 0 immediately; a later start replays from address 0 with word_cnt = 0; the entry {1,1,FFFF} issues csw only.

Source files
------------

// File: rtl/word_seq_1553_if.sv
// Host-load, control and encoder-transmit signals of the 1553 word sequencer.
// slave = sequencer side, master = host/encoder side.
interface word_seq_1553_if #(
    parameter int AW = 9,
    parameter int GW = 8
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [17:0]   wr_data;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic [AW-1:0] last_addr;
    logic [GW-1:0] gap_cycles;
    logic          tx_busy;
    logic [15:0]   tx_dword;
    logic          tx_csw;
    logic          tx_dw;
    logic          running;
    logic          done;
    logic          err_timeout;
    logic [AW-1:0] rd_addr;
    logic [15:0]   word_cnt;

    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, loop_en, last_addr, gap_cycles, tx_busy,
        output tx_dword, tx_csw, tx_dw, running, done, err_timeout, rd_addr, word_cnt
    );

    modport master (
        output wr_en, wr_addr, wr_data, start, stop, loop_en, last_addr, gap_cycles, tx_busy,
        input  tx_dword, tx_csw, tx_dw, running, done, err_timeout, rd_addr, word_cnt
    );
endinterface

// File: rtl/word_seq_1553.sv
// Replays a list of {csw, dw, dword} entries into a 1553 encoder, pacing each word
// on tx_busy with a programmable gap, loop/stop control and a busy-rise timeout.
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | entry read from memory into the transmit registers
// ISSUE     | strobe on the encoder interface (or end marker detected)
// WAIT_HI   | waiting for tx_busy to rise, timeout armed
// WAIT_LO   | waiting for tx_busy to fall
// GAP       | inter-word idle cycles
module word_seq_1553 #(
    parameter int DEPTH     = 512,
    parameter int AW        = 9,
    parameter int GW        = 8,
    parameter int TO_CYCLES = 16
) (
    input  logic           clk,
    input  logic           reset,
    word_seq_1553_if.slave bus
);
    localparam int TW = $clog2(TO_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_GAP
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [17:0]   r_mem [DEPTH];
    logic [15:0]   r_tx_dword;
    logic          r_tx_csw;
    logic          r_tx_dw;
    logic          r_done;
    logic          r_err;
    logic          r_stop_pend;
    logic [AW-1:0] r_rd_addr;
    logic [15:0]   r_word_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [GW-1:0] r_gap_cnt;

    logic [17:0]   w_rd_entry;
    logic          w_step;
    logic          w_end;
    logic          w_timeout;
    logic          w_gap_load;
    logic          w_stop;
    logic          w_at_last;
    logic          w_issued;

    assign w_rd_entry = r_mem[r_rd_addr];
    assign w_stop     = r_stop_pend | bus.stop;
    assign w_at_last  = (r_rd_addr == bus.last_addr);
    assign w_issued   = r_tx_csw | r_tx_dw;

    // Memory has no reset; a same-cycle write is seen by the following read only.
    always_ff @(posedge clk) begin
        if (bus.wr_en) r_mem[bus.wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step      = 1'b0;
        w_end       = 1'b0;
        w_timeout   = 1'b0;
        w_gap_load  = 1'b0;
        case (r_state)
            S_IDLE:    if (bus.start) w_state_nxt = S_FETCH;
            S_FETCH:   w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (w_issued) begin
                    w_state_nxt = S_WAIT_HI;
                end else begin
                    w_end       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_HI: begin
                if (bus.tx_busy) begin
                    w_state_nxt = S_WAIT_LO;
                end else if (r_to_cnt <= TW'(1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_LO: begin
                if (!bus.tx_busy) begin
                    if (bus.gap_cycles == '0) begin
                        w_step = 1'b1;
                    end else begin
                        w_gap_load  = 1'b1;
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_GAP:     if (r_gap_cnt <= GW'(1)) w_step = 1'b1;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (w_step) begin
            if (w_stop || (w_at_last && !bus.loop_en)) begin
                w_end       = 1'b1;
                w_state_nxt = S_IDLE;
            end else begin
                w_state_nxt = S_FETCH;
            end
        end
    end

    // Transmit registers double as the registered memory read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_dword  <= '0;
            r_tx_csw    <= 1'b0;
            r_tx_dw     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_stop_pend <= 1'b0;
            r_rd_addr   <= '0;
            r_word_cnt  <= '0;
            r_to_cnt    <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_tx_csw <= 1'b0;
            r_tx_dw  <= 1'b0;
            r_done   <= w_end;
            if (r_state == S_FETCH) begin
                r_tx_dword <= w_rd_entry[15:0];
                r_tx_csw   <= w_rd_entry[17];
                r_tx_dw    <= w_rd_entry[16] & ~w_rd_entry[17];
            end
            if (r_state == S_IDLE && bus.start) begin
                r_rd_addr  <= '0;
                r_word_cnt <= '0;
                r_err      <= 1'b0;
            end
            if (r_state == S_ISSUE && w_issued) begin
                if (r_word_cnt != 16'hFFFF) r_word_cnt <= r_word_cnt + 16'd1;
                r_to_cnt <= TW'(TO_CYCLES - 1);
            end else if (r_state == S_WAIT_HI && r_to_cnt != '0) begin
                r_to_cnt <= r_to_cnt - TW'(1);
            end
            if (w_timeout) r_err <= 1'b1;
            if (w_gap_load) begin
                r_gap_cnt <= bus.gap_cycles;
            end else if (r_state == S_GAP && r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - GW'(1);
            end
            if (w_step && w_state_nxt == S_FETCH) begin
                r_rd_addr <= w_at_last ? '0 : r_rd_addr + 1'b1;
            end
            if (w_state_nxt == S_IDLE) begin
                r_stop_pend <= 1'b0;
            end else if (bus.stop && r_state != S_IDLE) begin
                r_stop_pend <= 1'b1;
            end
        end
    end

    assign bus.tx_dword    = r_tx_dword;
    assign bus.tx_csw      = r_tx_csw;
    assign bus.tx_dw       = r_tx_dw;
    assign bus.running     = (r_state != S_IDLE);
    assign bus.done        = r_done;
    assign bus.err_timeout = r_err;
    assign bus.rd_addr     = r_rd_addr;
    assign bus.word_cnt    = r_word_cnt;
endmodule

// File: tb/tb_word_seq_1553.sv
// Directed bench for word_seq_1553: scenario table plus hand-written corner sequences,
// with a simple encoder model that holds tx_busy for a set number of cycles per strobe.
module tb_word_seq_1553;
    localparam int AW = 9;
    localparam int GW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    word_seq_1553_if #(.AW(AW), .GW(GW)) bus ();

    word_seq_1553 #(.DEPTH(512), .AW(AW), .GW(GW), .TO_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // encoder model
    bit enc_en = 1'b1;
    int busy_len = 40;
    int busy_left = 0;
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            bus.tx_busy = 1'b0;
            busy_left   = 0;
        end else if (enc_en && (bus.tx_csw || bus.tx_dw)) begin
            bus.tx_busy = 1'b1;
            busy_left   = busy_len;
        end else begin
            bus.tx_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end
    end

    int          s_cyc[$];
    logic [15:0] s_dword[$];
    logic        s_csw[$];
    logic        s_dw[$];
    logic [8:0]  s_addr[$];
    logic [15:0] s_cnt[$];
    int done_cnt, done_cyc, err_cyc, start_cyc;
    logic err_first;

    typedef struct {
        int marker;
        int loop_en;
        int last;
        int gap;
        int busy;
        int stop_word;
        int exp_n;
        int exp_space;
        int exp_dly;
        int exp_cnt;
    } scen_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [17:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(addr);
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge of the first IDLE cycle.
    task automatic run_seq(input int stop_word, input int budget, output bit fin);
        bit stopped = 1'b0;
        s_cyc.delete(); s_dword.delete(); s_csw.delete();
        s_dw.delete();  s_addr.delete();  s_cnt.delete();
        done_cnt = 0; done_cyc = -1; err_cyc = -1; fin = 1'b0;
        bus.start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < budget && !fin; k++) begin
            if (k == 0) err_first = bus.err_timeout;
            if (bus.tx_csw || bus.tx_dw) begin
                s_cyc.push_back(cyc);
                s_dword.push_back(bus.tx_dword);
                s_csw.push_back(bus.tx_csw);
                s_dw.push_back(bus.tx_dw);
                s_addr.push_back(bus.rd_addr);
                s_cnt.push_back(bus.word_cnt);
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.err_timeout && err_cyc < 0) err_cyc = cyc;
            if (stop_word > 0 && !stopped && s_cyc.size() == stop_word &&
                cyc - s_cyc[s_cyc.size()-1] == 1) begin
                bus.stop = 1'b1;
                stopped  = 1'b1;
            end else begin
                bus.stop = 1'b0;
            end
            if (!bus.running) fin = 1'b1;
            else @(negedge clk);
        end
        bus.stop = 1'b0;
    endtask

    initial begin
        scen_t       sc[4];
        logic [15:0] exp_dword[3];
        logic        exp_csw[3];
        bit          fin;
        int          n, seen;
        logic [17:0] d;

        //        mark loop last gap busy stop  n  space dly cnt
        sc[0] = '{0,   0,   2,   4,  40,  0,    3, 47,   46, 3};
        sc[1] = '{0,   1,   2,   4,  40,  5,    5, 47,   46, 5};
        sc[2] = '{1,   0,   5,   4,  40,  0,    1, 0,    48, 1};
        sc[3] = '{0,   0,   1,   0,  10,  0,    2, 13,   12, 2};
        exp_dword = '{16'h5555, 16'hABCD, 16'h1234};
        exp_csw   = '{1'b1, 1'b0, 1'b0};

        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0;
        bus.last_addr = '0; bus.gap_cycles = '0;

        repeat (3) @(negedge clk);
        chk("rst_running", bus.running, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err_timeout, 0);
        chk("rst_csw", bus.tx_csw, 0);
        chk("rst_dw", bus.tx_dw, 0);
        chk("rst_dword", bus.tx_dword, 0);
        chk("rst_word_cnt", bus.word_cnt, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        reset = 1'b0;
        @(negedge clk);

        wr(0, {2'b10, 16'h5555});
        wr(1, {2'b01, 16'hABCD});
        wr(2, {2'b01, 16'h1234});

        for (int si = 0; si < 4; si++) begin
            if (sc[si].marker != 0) wr(1, {2'b00, 16'h7777});
            bus.loop_en    = sc[si].loop_en[0];
            bus.last_addr  = AW'(sc[si].last);
            bus.gap_cycles = GW'(sc[si].gap);
            busy_len       = sc[si].busy;
            run_seq(sc[si].stop_word, 2000, fin);
            chk($sformatf("s%0d_fin", si), fin, 1);
            chk($sformatf("s%0d_nwords", si), s_cyc.size(), sc[si].exp_n);
            n = (s_cyc.size() < sc[si].exp_n) ? s_cyc.size() : sc[si].exp_n;
            if (n > 0) chk($sformatf("s%0d_latency", si), s_cyc[0] - start_cyc, 2);
            for (int i = 0; i < n; i++) begin
                chk($sformatf("s%0d_w%0d_dword", si, i), s_dword[i], exp_dword[i % 3]);
                chk($sformatf("s%0d_w%0d_csw", si, i), s_csw[i], exp_csw[i % 3]);
                chk($sformatf("s%0d_w%0d_dw", si, i), s_dw[i], !exp_csw[i % 3]);
                if (i > 0) chk($sformatf("s%0d_w%0d_space", si, i), s_cyc[i] - s_cyc[i-1], sc[si].exp_space);
            end
            chk($sformatf("s%0d_done_cnt", si), done_cnt, 1);
            if (n > 0) chk($sformatf("s%0d_done_dly", si), done_cyc - s_cyc[n-1], sc[si].exp_dly);
            chk($sformatf("s%0d_word_cnt", si), bus.word_cnt, sc[si].exp_cnt);
            chk($sformatf("s%0d_err", si), bus.err_timeout, 0);
            if (sc[si].marker != 0) wr(1, {2'b01, 16'hABCD});
        end

        // encoder never answers
        enc_en = 1'b0;
        bus.loop_en = 1'b0; bus.last_addr = AW'(2); bus.gap_cycles = GW'(4); busy_len = 40;
        run_seq(0, 200, fin);
        chk("to_fin", fin, 1);
        chk("to_nwords", s_cyc.size(), 1);
        if (s_cyc.size() > 0) chk("to_delay", err_cyc - s_cyc[0], 16);
        chk("to_err", bus.err_timeout, 1);
        chk("to_no_done", done_cnt, 0);
        enc_en = 1'b1;
        run_seq(0, 2000, fin);
        chk("to_clear", err_first, 0);
        chk("to_rerun_nwords", s_cyc.size(), 3);
        chk("to_rerun_done", done_cnt, 1);
        chk("to_rerun_err", bus.err_timeout, 0);

        // address wrap with gap 0
        for (int i = 0; i < 512; i++) begin
            d = {(i == 0), (i != 0), 16'(i) ^ 16'h5A00};
            wr(i, d);
        end
        bus.loop_en = 1'b1; bus.last_addr = AW'(511); bus.gap_cycles = '0; busy_len = 2;
        run_seq(513, 5000, fin);
        chk("wrap_fin", fin, 1);
        chk("wrap_nwords", s_cyc.size(), 513);
        if (s_cyc.size() >= 513) begin
            chk("wrap_addr511", s_addr[511], 511);
            chk("wrap_dword511", s_dword[511], 16'h5BFF);
            chk("wrap_addr0", s_addr[512], 0);
            chk("wrap_dword0", s_dword[512], 16'h5A00);
            chk("wrap_csw0", s_csw[512], 1);
            chk("wrap_space", s_cyc[512] - s_cyc[511], 5);
            chk("wrap_done_dly", done_cyc - s_cyc[512], 4);
        end
        chk("wrap_word_cnt", bus.word_cnt, 513);
        chk("wrap_done_cnt", done_cnt, 1);

        // reset in WAIT_LO, then replay with a csw+dw entry
        wr(0, {2'b11, 16'hFFFF});
        wr(1, {2'b01, 16'h0BAD});
        bus.loop_en = 1'b0; bus.last_addr = AW'(1); bus.gap_cycles = GW'(4); busy_len = 40;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        for (int k = 0; k < 200 && seen < 2; k++) begin
            @(negedge clk);
            if (bus.tx_csw || bus.tx_dw) seen++;
        end
        chk("mid_seen", seen, 2);
        repeat (10) @(negedge clk);
        chk("mid_running", bus.running, 1);
        chk("mid_rd_addr", bus.rd_addr, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_running", bus.running, 0);
        chk("mid_rst_rd_addr", bus.rd_addr, 0);
        chk("mid_rst_word_cnt", bus.word_cnt, 0);
        chk("mid_rst_dword", bus.tx_dword, 0);
        chk("mid_rst_done", bus.done, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_seq(0, 500, fin);
        chk("replay_fin", fin, 1);
        chk("replay_nwords", s_cyc.size(), 2);
        if (s_cyc.size() >= 2) begin
            chk("replay_latency", s_cyc[0] - start_cyc, 2);
            chk("replay_cnt0", s_cnt[0], 0);
            chk("replay_csw", s_csw[0], 1);
            chk("replay_dw", s_dw[0], 0);
            chk("replay_dword0", s_dword[0], 16'hFFFF);
            chk("replay_dword1", s_dword[1], 16'h0BAD);
        end
        chk("replay_word_cnt", bus.word_cnt, 2);
        chk("replay_done", done_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
